// File: rtl/rob_commit_ctrl.sv
// In-order reorder-buffer allocation/commit controller feeding the alias-table commit port.
// Optional feature macro: ROB_STALL_CNT_EN (saturating allocation-stall counter on stall_cycles_o).
module rob_commit_ctrl #(
  parameter int ROB_IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req_i,
  input  logic [4:0]           alloc_rd_i,
  output logic                 alloc_gnt_o,
  output logic [ROB_IDX_W-1:0] alloc_idx_o,
  input  logic                 wb_valid_i,
  input  logic [ROB_IDX_W-1:0] wb_idx_i,
  input  logic [31:0]          wb_data_i,
  input  logic                 flush_req_i,
  input  logic [ROB_IDX_W-1:0] flush_idx_i,
  output logic                 rat_we_o,
  output logic [4:0]           rat_addr_o,
  output logic [31:0]          rat_data_o,
  output logic [ROB_IDX_W-1:0] rat_idx_o,
  output logic                 rat_rollback_o,
  output logic [ROB_IDX_W:0]   occupancy_o,
  output logic [31:0]          stall_cycles_o
);
  localparam int DEPTH = 2 ** ROB_IDX_W;
  localparam logic [ROB_IDX_W:0] FULL_C = {1'b1, {ROB_IDX_W{1'b0}}};

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [ROB_IDX_W-1:0]   head_q, head_d, tail_q, tail_d, fidx_q, fidx_d;
  logic [ROB_IDX_W:0]     occ_q, occ_d;
  logic [DEPTH-1:0]       live_q, live_d, done_q, done_d;
  logic [4:0]             rd_q   [DEPTH];
  logic [31:0]            data_q [DEPTH];

  logic alloc_gnt_s, retire_s, wb_ok_s, flush_ok_s, rollback_s;

  assign alloc_gnt_s = alloc_req_i & (state_q == RUN) & ~flush_req_i & (occ_q != FULL_C);
  assign retire_s    = (state_q != FLUSH) & (occ_q != '0) & done_q[head_q];
  // A grant targets a non-live slot, so this only guards the same-cycle reuse case.
  assign wb_ok_s     = wb_valid_i & live_q[wb_idx_i] & ~(alloc_gnt_s & (wb_idx_i == tail_q));
  assign flush_ok_s  = (state_q == RUN) & flush_req_i & live_q[flush_idx_i];

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    fidx_d     = fidx_q;
    live_d     = live_q;
    done_d     = done_q;
    rollback_s = 1'b0;

    case (state_q)
      RUN: begin
        if (flush_ok_s) begin
          fidx_d  = flush_idx_i;
          state_d = (retire_s && (head_q == flush_idx_i)) ? FLUSH : DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (retire_s && (head_q == fidx_q)) begin
          state_d = FLUSH;
        end else begin
          state_d = DRAIN;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase

    if (state_q == FLUSH) begin
      rollback_s = 1'b1;
      live_d     = '0;
      done_d     = '0;
      head_d     = '0;
      tail_d     = '0;
      occ_d      = '0;
    end else begin
      if (wb_ok_s) begin
        done_d[wb_idx_i] = 1'b1;
      end else begin
        done_d = done_d;
      end
      if (retire_s) begin
        live_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + ROB_IDX_W'(1);
      end else begin
        head_d = head_q;
      end
      if (alloc_gnt_s) begin
        live_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        tail_d         = tail_q + ROB_IDX_W'(1);
      end else begin
        tail_d = tail_q;
      end
      occ_d = occ_q + {{ROB_IDX_W{1'b0}}, alloc_gnt_s} - {{ROB_IDX_W{1'b0}}, retire_s};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      fidx_q  <= '0;
      occ_q   <= '0;
      live_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fidx_q  <= fidx_d;
      occ_q   <= occ_d;
      live_q  <= live_d;
      done_q  <= done_d;
    end
  end

  // Payload storage is cleared on reset so the commit port reads zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      if (alloc_gnt_s) rd_q[tail_q] <= alloc_rd_i;
      if (wb_ok_s)     data_q[wb_idx_i] <= wb_data_i;
    end
  end

  assign alloc_gnt_o    = alloc_gnt_s;
  assign alloc_idx_o    = tail_q;
  assign rat_we_o       = retire_s & (rd_q[head_q] != 5'd0);
  assign rat_addr_o     = rd_q[head_q];
  assign rat_data_o     = data_q[head_q];
  assign rat_idx_o      = head_q;
  assign rat_rollback_o = rollback_s;
  assign occupancy_o    = occ_q;

`ifdef ROB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (alloc_req_i && !alloc_gnt_s && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model of the reorder buffer.
module tb_rob_commit_ctrl;
  localparam int W     = 3;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         alloc_req, wb_valid, flush_req;
  logic [4:0]   alloc_rd;
  logic [W-1:0] wb_idx, flush_idx;
  logic [31:0]  wb_data;
  logic         alloc_gnt, rat_we, rat_rollback;
  logic [W-1:0] alloc_idx, rat_idx;
  logic [4:0]   rat_addr;
  logic [31:0]  rat_data, stall_cycles;
  logic [W:0]   occupancy;

  always #5 clk = ~clk;

  rob_commit_ctrl #(.ROB_IDX_W(W)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req), .alloc_rd_i(alloc_rd),
    .alloc_gnt_o(alloc_gnt), .alloc_idx_o(alloc_idx),
    .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data),
    .flush_req_i(flush_req), .flush_idx_i(flush_idx),
    .rat_we_o(rat_we), .rat_addr_o(rat_addr), .rat_data_o(rat_data), .rat_idx_o(rat_idx),
    .rat_rollback_o(rat_rollback), .occupancy_o(occupancy), .stall_cycles_o(stall_cycles)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the ROB as an ordered queue of live entries.
  typedef struct {
    int          idx;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          done;
  } ent_t;

  ent_t        mq[$];
  int          m_tail, m_mode, m_fidx;   // mode 0 run, 1 draining, 2 rollback cycle
  logic [31:0] m_stall;
  logic        e_gnt, e_retire, e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic [W-1:0] e_ridx;
  int          n_rb;
  logic [7:0]  commit_mask;

  task automatic model_reset();
    mq.delete();
    m_tail = 0; m_mode = 0; m_fidx = 0; m_stall = 32'd0;
    n_rb = 0; commit_mask = 8'd0;
  endtask

  task automatic model_eval();
    e_gnt    = alloc_req && (m_mode == 0) && !flush_req && (mq.size() < DEPTH);
    e_retire = 1'b0; e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0; e_ridx = '0;
    if (m_mode != 2 && mq.size() > 0) begin
      if (mq[0].done) begin
        e_retire = 1'b1;
        e_we     = (mq[0].rd != 5'd0);
        e_addr   = mq[0].rd;
        e_data   = mq[0].data;
        e_ridx   = W'(mq[0].idx);
      end
    end
  endtask

  task automatic model_update();
    bit   lv;
    ent_t e;
    lv = 0;
    foreach (mq[i]) if (mq[i].idx == int'(flush_idx)) lv = 1;
    if (m_mode == 2) begin
      mq.delete(); m_tail = 0; m_mode = 0;
    end else begin
      if (wb_valid && !(e_gnt && int'(wb_idx) == m_tail))
        foreach (mq[i]) if (mq[i].idx == int'(wb_idx)) begin mq[i].data = wb_data; mq[i].done = 1; end
      if (m_mode == 0 && flush_req && lv) begin
        m_fidx = int'(flush_idx);
        m_mode = (e_retire && mq[0].idx == m_fidx) ? 2 : 1;
      end else if (m_mode == 1 && e_retire && mq[0].idx == m_fidx) begin
        m_mode = 2;
      end
      if (e_retire) void'(mq.pop_front());
      if (e_gnt) begin
        e.idx = m_tail; e.rd = alloc_rd; e.data = 32'd0; e.done = 0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    if (alloc_req && !e_gnt && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
  endtask

  // One clock: compare combinational outputs against the model, then advance both.
  task automatic cycle();
    #1;
    model_eval();
    check("alloc_gnt", 64'(alloc_gnt), 64'(e_gnt));
    check("alloc_idx", 64'(alloc_idx), 64'(m_tail));
    check("rat_we", 64'(rat_we), 64'(e_we));
    if (e_retire) begin
      check("rat_addr", 64'(rat_addr), 64'(e_addr));
      check("rat_data", 64'(rat_data), 64'(e_data));
      check("rat_idx", 64'(rat_idx), 64'(e_ridx));
    end
    check("rat_rollback", 64'(rat_rollback), 64'(m_mode == 2));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
`ifdef ROB_STALL_CNT_EN
    check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`else
    check("stall_cycles", 64'(stall_cycles), 64'(0));
`endif
    if (rat_rollback) n_rb++;
    if (rat_we) commit_mask[rat_idx] = 1'b1;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    alloc_req = 1'b0; alloc_rd = 5'd0; wb_valid = 1'b0; wb_idx = '0;
    wb_data = 32'd0; flush_req = 1'b0; flush_idx = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd);
    set_idle(); alloc_req = 1'b1; alloc_rd = rd;
  endtask

  task automatic wb(input logic [W-1:0] idx, input logic [31:0] d);
    set_idle(); wb_valid = 1'b1; wb_idx = idx; wb_data = d;
  endtask

  typedef struct {
    logic         req;  logic [4:0]  rd;
    logic         wbv;  logic [W-1:0] wbi; logic [31:0] wbd;
    logic         gnt;  logic [W-1:0] aidx;
    logic         we;   logic [4:0]  addr; logic [31:0] data; logic [W-1:0] ridx;
    logic [W:0]   occ;
  } vec_t;

  vec_t tv[13];

  initial begin
    tv[0]  = '{1'b1, 5'd1, 1'b0, 3'd0, 32'h0,    1'b1, 3'd0, 1'b0, 5'd0, 32'h0,  3'd0, 4'd0};
    tv[1]  = '{1'b1, 5'd2, 1'b0, 3'd0, 32'h0,    1'b1, 3'd1, 1'b0, 5'd0, 32'h0,  3'd0, 4'd1};
    tv[2]  = '{1'b1, 5'd3, 1'b0, 3'd0, 32'h0,    1'b1, 3'd2, 1'b0, 5'd0, 32'h0,  3'd0, 4'd2};
    tv[3]  = '{1'b0, 5'd0, 1'b1, 3'd2, 32'h33,   1'b0, 3'd3, 1'b0, 5'd0, 32'h0,  3'd0, 4'd3};
    tv[4]  = '{1'b0, 5'd0, 1'b1, 3'd0, 32'h11,   1'b0, 3'd3, 1'b0, 5'd0, 32'h0,  3'd0, 4'd3};
    tv[5]  = '{1'b0, 5'd0, 1'b1, 3'd1, 32'h22,   1'b0, 3'd3, 1'b1, 5'd1, 32'h11, 3'd0, 4'd3};
    tv[6]  = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,    1'b0, 3'd3, 1'b1, 5'd2, 32'h22, 3'd1, 4'd2};
    tv[7]  = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,    1'b0, 3'd3, 1'b1, 5'd3, 32'h33, 3'd2, 4'd1};
    tv[8]  = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,    1'b0, 3'd3, 1'b0, 5'd0, 32'h0,  3'd0, 4'd0};
    tv[9]  = '{1'b1, 5'd0, 1'b0, 3'd0, 32'h0,    1'b1, 3'd3, 1'b0, 5'd0, 32'h0,  3'd0, 4'd0};
    tv[10] = '{1'b0, 5'd0, 1'b1, 3'd3, 32'hDEAD, 1'b0, 3'd4, 1'b0, 5'd0, 32'h0,  3'd0, 4'd1};
    tv[11] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,    1'b0, 3'd4, 1'b0, 5'd0, 32'h0,  3'd0, 4'd1};
    tv[12] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h0,    1'b0, 3'd4, 1'b0, 5'd0, 32'h0,  3'd0, 4'd0};

    // Reset state
    set_idle();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_gnt", 64'(alloc_gnt), 64'(0));
    check("rst_idx", 64'(alloc_idx), 64'(0));
    check("rst_we", 64'(rat_we), 64'(0));
    check("rst_rb", 64'(rat_rollback), 64'(0));
    check("rst_occ", 64'(occupancy), 64'(0));
    check("rst_stall", 64'(stall_cycles), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // In-order commit with out-of-order writeback, then a silent rd=0 retire
    for (int i = 0; i < 13; i++) begin
      set_idle();
      alloc_req = tv[i].req; alloc_rd = tv[i].rd;
      wb_valid = tv[i].wbv; wb_idx = tv[i].wbi; wb_data = tv[i].wbd;
      #1;
      check($sformatf("tv%0d_gnt", i), 64'(alloc_gnt), 64'(tv[i].gnt));
      check($sformatf("tv%0d_aidx", i), 64'(alloc_idx), 64'(tv[i].aidx));
      check($sformatf("tv%0d_we", i), 64'(rat_we), 64'(tv[i].we));
      check($sformatf("tv%0d_occ", i), 64'(occupancy), 64'(tv[i].occ));
      if (tv[i].we) begin
        check($sformatf("tv%0d_addr", i), 64'(rat_addr), 64'(tv[i].addr));
        check($sformatf("tv%0d_data", i), 64'(rat_data), 64'(tv[i].data));
        check($sformatf("tv%0d_ridx", i), 64'(rat_idx), 64'(tv[i].ridx));
      end
      cycle();
    end

    // Full ROB blocks allocation; slot 0 is reused after it retires
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin alloc(5'(i + 1)); cycle(); end
    alloc(5'd9); #1;
    check("full_gnt", 64'(alloc_gnt), 64'(0));
    cycle();
    wb(3'd0, 32'hA0); cycle();
    set_idle(); cycle();
    alloc(5'd9); #1;
    check("wrap_gnt", 64'(alloc_gnt), 64'(1));
    check("wrap_idx", 64'(alloc_idx), 64'(0));
`ifdef ROB_STALL_CNT_EN
    check("wrap_stall", 64'(stall_cycles), 64'(1));
`else
    check("wrap_stall", 64'(stall_cycles), 64'(0));
`endif
    cycle();

    // Mispredict at idx 2: drain 0..2, younger entries dropped, single rollback
    do_reset();
    for (int i = 0; i < 5; i++) begin alloc(5'(i + 1)); cycle(); end
    alloc(5'd7); flush_req = 1'b1; flush_idx = 3'd2; #1;
    check("flush_gnt", 64'(alloc_gnt), 64'(0));
    cycle();
    wb(3'd4, 32'h44); alloc_req = 1'b1; cycle();
    wb(3'd3, 32'h33); cycle();
    wb(3'd0, 32'h10); flush_req = 1'b1; flush_idx = 3'd1; cycle();
    wb(3'd1, 32'h20); cycle();
    wb(3'd2, 32'h30); alloc_req = 1'b1; cycle();
    alloc(5'd7); cycle();
    alloc(5'd7); #1;
    check("fl_rollback", 64'(rat_rollback), 64'(1));
    check("fl_gnt", 64'(alloc_gnt), 64'(0));
    cycle();
    alloc(5'd7); #1;
    check("post_rollback", 64'(rat_rollback), 64'(0));
    check("post_gnt", 64'(alloc_gnt), 64'(1));
    check("post_idx", 64'(alloc_idx), 64'(0));
    check("post_occ", 64'(occupancy), 64'(0));
    cycle();
    check("fl_rb_count", 64'(n_rb), 64'(1));
    check("fl_commits", 64'(commit_mask), 64'(8'b0000_0111));

    // Ignored writeback and flush to non-live entries
    do_reset();
    wb(3'd5, 32'hBAD); cycle();
    set_idle(); flush_req = 1'b1; flush_idx = 3'd6; cycle();
    alloc(5'd4); #1;
    check("ign_gnt", 64'(alloc_gnt), 64'(1));
    check("ign_occ", 64'(occupancy), 64'(0));
    cycle();

    // Asynchronous reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 3; i++) begin alloc(5'(i + 1)); cycle(); end
    wb(3'd0, 32'h5); flush_req = 1'b1; flush_idx = 3'd1; cycle();
    set_idle();
    #2 rst = 1'b1;
    #1;
    check("arst_we", 64'(rat_we), 64'(0));
    check("arst_addr", 64'(rat_addr), 64'(0));
    check("arst_data", 64'(rat_data), 64'(0));
    check("arst_ridx", 64'(rat_idx), 64'(0));
    check("arst_idx", 64'(alloc_idx), 64'(0));
    check("arst_occ", 64'(occupancy), 64'(0));
    check("arst_rb", 64'(rat_rollback), 64'(0));
    model_reset();
    @(negedge clk);
    check("arst_rb_hold", 64'(rat_rollback), 64'(0));
    rst = 1'b0;
    set_idle(); cycle();
    alloc(5'd2); #1;
    check("arst_run_gnt", 64'(alloc_gnt), 64'(1));
    cycle();

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      set_idle();
      alloc_req = ($urandom_range(0, 9) < 6);
      alloc_rd  = 5'($urandom_range(0, 31));
      wb_valid  = ($urandom_range(0, 1) == 1);
      wb_data   = $urandom;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        wb_idx = W'(mq[$urandom_range(0, mq.size() - 1)].idx);
      else
        wb_idx = W'($urandom_range(0, DEPTH - 1));
      flush_req = ($urandom_range(0, 29) == 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        flush_idx = W'(mq[$urandom_range(0, mq.size() - 1)].idx);
      else
        flush_idx = W'($urandom_range(0, DEPTH - 1));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rob_commit_ctrl.md
# rob_commit_ctrl

In-order allocation and commit controller for the reorder buffer that feeds the register alias table. It hands out ROB indices to decode, records the destination register and writeback result for each entry, and retires the oldest completed entry each cycle onto the alias table's commit port (`rat_we`/`rat_addr`/`rat_data`/`rat_idx`). On a branch mispredict it drains all entries up to and including the branch, then pulses the alias table rollback.

## Interface
- `ROB_IDX_W`, default 3: index width; `DEPTH = 2**ROB_IDX_W` entries. Must match the ROB entry width used by the alias table.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `alloc_req` in 1: decode requests an entry.
- `alloc_rd` in 5: destination register of the requesting instruction (0 means no destination).
- `alloc_gnt` out 1: allocation accepted this cycle.
- `alloc_idx` out ROB_IDX_W: index granted, which equals the tail pointer.
- `wb_valid` in 1: an execution result is available.
- `wb_idx` in ROB_IDX_W: entry being written back.
- `wb_data` in 32: result value.
- `flush_req` in 1: mispredict report.
- `flush_idx` in ROB_IDX_W: ROB index of the mispredicted branch.
- `rat_we` out 1: commit write to the alias table.
- `rat_addr` out 5: committed destination register.
- `rat_data` out 32: committed value.
- `rat_idx` out ROB_IDX_W: committed entry index.
- `rat_rollback` out 1: one-cycle rollback pulse to the alias table.
- `occupancy` out ROB_IDX_W+1: number of live entries.
- `stall_cycles` out 32: allocation-stall counter (see Configuration).

## Operation
- **Storage.** Each entry holds `rd[4:0]`, `data[31:0]`, `live` and `done`. Head and tail pointers are ROB_IDX_W wide and wrap modulo DEPTH. `occupancy` is a separate counter.
- **FSM states:**
  - RUN → DRAIN on `flush_req`.
  - RUN → FLUSH directly if the entry at `flush_idx` retires in the same cycle as `flush_req`.
  - DRAIN → FLUSH in the cycle the entry at `flush_idx` retires.
  - FLUSH → RUN unconditionally after one cycle.
- **Allocation.** `alloc_gnt = alloc_req & state==RUN & !flush_req & occupancy!=DEPTH`.
  - A full ROB blocks allocation even if a retire happens in the same cycle.
  - On grant: the entry is written with rd, `live=1`, `done=0`; tail increments.
- **Writeback.** When `wb_valid` and `live[wb_idx]`, store `wb_data` and set `done`.
  - Writeback to a non-live entry is ignored.
  - Writeback to the index being allocated in the same cycle is ignored.
- **Retire.** Retire occurs when `state!=FLUSH & occupancy!=0 & done[head]`.
  - `rat_addr`, `rat_data` and `rat_idx` come from the head entry; `rat_idx` equals head.
  - `rat_we = retire & rd!=0`. An entry with rd=0 retires silently.
  - On retire: `live` and `done` are cleared and head increments.
- **Flush.** `flush_req` is honoured only in RUN and only if `live[flush_idx]`; otherwise it is ignored.
  - Allocation stays blocked through DRAIN and FLUSH.
  - In FLUSH: `rat_rollback=1`, all `live`/`done` bits are cleared, head=tail=0, occupancy=0.
- **Occupancy update.** occupancy changes by +grant −retire; a simultaneous grant and retire leaves it unchanged.
- **Reset values.** All outputs are 0, head=tail=0, occupancy=0, all `live`/`done`=0, state=RUN, `stall_cycles`=0.

## Timing
- `alloc_gnt`, `alloc_idx`, all `rat_*` outputs and `occupancy` are combinational from state and registers. All state updates happen on the rising edge of `clk`.
- Writeback-to-retire latency is at least 1 cycle: `done` is registered, so an entry written back at cycle N retires at cycle N+1 at the earliest.
- Throughput is at most one allocation and one retire per cycle.
- A mispredict whose branch is already at head and done takes this path:
  - `flush_req` at cycle N: retire plus transition to FLUSH.
  - N+1: `rat_rollback` pulse.
  - N+2: RUN, and grants are possible again.
- Asserting `rst` mid-operation clears everything immediately (asynchronously), with no rollback pulse.

## Configuration
- `ROB_STALL_CNT_EN` defined: `stall_cycles` increments in every cycle where `alloc_req & !alloc_gnt`. It saturates at 0xFFFFFFFF and is cleared only by `rst`.
- `ROB_STALL_CNT_EN` undefined: `stall_cycles` is tied to 0 and no counter logic is built.

## Test plan
- **Reset, allocate and retire in order.** With DEPTH=8, after reset allocate rd=1,2,3 (indices 0,1,2), then write back 0x11, 0x22, 0x33 out of order (2,0,1) → commits rd1=0x11 idx0, rd2=0x22 idx1, rd3=0x33 idx2 on consecutive cycles; `occupancy` returns to 0.
- **Full and wrap.** Allocate 8 entries → the 9th request gets `alloc_gnt=0`. Retire idx0 and allocate in the next cycle → grant with `alloc_idx=0` (wrap); `stall_cycles`=1 when the macro is enabled.
- **rd=0 entry.** Allocate rd=0 and write back 0xDEAD → the entry retires with `rat_we=0`, head advances, and `occupancy` decrements.
- **Mispredict drain.** Set up entries 0..4 live with the branch at idx 2 and `flush_req` with `flush_idx=2` → idx 0, 1, 2 commit after writeback, while idx 3 and 4 are never committed. `rat_rollback` pulses for one cycle after idx 2 retires; then head=tail=0, `occupancy`=0, and `alloc_req` during DRAIN/FLUSH is denied.
- **Ignored events.** Writeback to a non-live idx 5 → no state change. `flush_req` to a non-live idx → stays in RUN. A second `flush_req` during DRAIN → ignored.
- **Asynchronous reset mid-DRAIN.** Assert `rst` between clock edges → all outputs go to 0 immediately, state=RUN, and no `rat_rollback` is asserted.
